// File: rtl/alu_op_sequencer_if.sv
// Bundles the board-side signals (switches, load button, status) and the ALU-side signals
// (operands, opcode, ALU result) that connect to the operation sequencer.
//   slave  : used by the sequencer (inputs i_*, outputs o_*)
//   master : used by the environment that drives switches/button and hosts the ALU
interface alu_op_sequencer_if #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = 6
);
  logic [NB_DATA-1:0] i_sw;
  logic               i_load;
  logic [NB_DATA-1:0] i_alu_res;
  logic [NB_DATA-1:0] o_dato_a;
  logic [NB_DATA-1:0] o_dato_b;
  logic [NB_OP-1:0]   o_opcode;
  logic [NB_DATA-1:0] o_result;
  logic               o_done;
  logic               o_err;
  logic [2:0]         o_state;

  modport slave (
    input  i_sw, i_load, i_alu_res,
    output o_dato_a, o_dato_b, o_opcode, o_result, o_done, o_err, o_state
  );

  modport master (
    output i_sw, i_load, i_alu_res,
    input  o_dato_a, o_dato_b, o_opcode, o_result, o_done, o_err, o_state
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences an external combinational ALU from one switch bus and one load button.
// Three load presses capture operand A, operand B and the opcode; the ALU result is then
// latched one cycle later. Unsupported opcodes set a sticky error and finish immediately.
// Ports:
//   clk    : system clock, all state on rising edge
//   reset  : synchronous, active-high reset
//   bus    : alu_op_sequencer_if.slave
//            i_sw (switches), i_load (debounced button level), i_alu_res (ALU output),
//            o_dato_a/o_dato_b/o_opcode (to ALU), o_result (latched result),
//            o_done (one-cycle pulse), o_err (sticky unsupported opcode), o_state (FSM for LEDs)
module alu_op_sequencer #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = 6
) (
  input logic                clk,
  input logic                reset,
  alu_op_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    StA    = 3'd0,
    StB    = 3'd1,
    StOp   = 3'd2,
    StExec = 3'd3,
    StDone = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               load_q;
  logic               load_edge;
  logic [NB_DATA-1:0] dato_a_q, dato_a_d;
  logic [NB_DATA-1:0] dato_b_q, dato_b_d;
  logic [NB_OP-1:0]   opcode_q, opcode_d;
  logic [NB_DATA-1:0] result_q, result_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [NB_OP-1:0]   sw_op;

  // MIPS funct codes the ALU implements.
  function automatic logic op_supported(input logic [NB_OP-1:0] op);
    logic ok;
    ok = 1'b0;
    if (op == NB_OP'(6'b100000) || op == NB_OP'(6'b100010) ||
        op == NB_OP'(6'b100100) || op == NB_OP'(6'b100101) ||
        op == NB_OP'(6'b100110) || op == NB_OP'(6'b100111) ||
        op == NB_OP'(6'b000011) || op == NB_OP'(6'b000010)) begin
      ok = 1'b1;
    end
    return ok;
  endfunction

  assign load_edge = bus.i_load & ~load_q;
  assign sw_op     = bus.i_sw[NB_OP-1:0];

  always_comb begin
    state_d  = state_q;
    dato_a_d = dato_a_q;
    dato_b_d = dato_b_q;
    opcode_d = opcode_q;
    result_d = result_q;
    err_d    = err_q;
    done_d   = 1'b0;
    case (state_q)
      StA: begin
        if (load_edge) begin
          dato_a_d = bus.i_sw;
          err_d    = 1'b0;
          state_d  = StB;
        end
      end
      StB: begin
        if (load_edge) begin
          dato_b_d = bus.i_sw;
          state_d  = StOp;
        end
      end
      StOp: begin
        if (load_edge) begin
          opcode_d = sw_op;
          if (op_supported(sw_op)) begin
            state_d = StExec;
          end else begin
            err_d    = 1'b1;
            result_d = '0;
            done_d   = 1'b1;
            state_d  = StDone;
          end
        end
      end
      StExec: begin
        // Opcode registered last edge; ALU output has settled. Any load edge here is dropped.
        result_d = bus.i_alu_res;
        done_d   = 1'b1;
        state_d  = StDone;
      end
      StDone: begin
        if (load_edge) begin
          dato_a_d = bus.i_sw;
          err_d    = 1'b0;
          state_d  = StB;
        end
      end
      default: state_d = StA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StA;
      // Treat the button as already pressed so a press held through reset is not an edge.
      load_q   <= 1'b1;
      dato_a_q <= '0;
      dato_b_q <= '0;
      opcode_q <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      load_q   <= bus.i_load;
      dato_a_q <= dato_a_d;
      dato_b_q <= dato_b_d;
      opcode_q <= opcode_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.o_dato_a = dato_a_q;
  assign bus.o_dato_b = dato_b_q;
  assign bus.o_opcode = opcode_q;
  assign bus.o_result = result_q;
  assign bus.o_done   = done_q;
  assign bus.o_err    = err_q;
  assign bus.o_state  = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  logic clk;
  logic reset;

  alu_op_sequencer_if #(.NB_DATA(8), .NB_OP(6)) bus ();

  alu_op_sequencer #(.NB_DATA(8), .NB_OP(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU hosted by the environment.
  always_comb begin
    case (bus.o_opcode)
      6'h20:   bus.i_alu_res = bus.o_dato_a + bus.o_dato_b;
      6'h22:   bus.i_alu_res = bus.o_dato_a - bus.o_dato_b;
      6'h24:   bus.i_alu_res = bus.o_dato_a & bus.o_dato_b;
      6'h25:   bus.i_alu_res = bus.o_dato_a | bus.o_dato_b;
      6'h26:   bus.i_alu_res = bus.o_dato_a ^ bus.o_dato_b;
      6'h27:   bus.i_alu_res = ~(bus.o_dato_a | bus.o_dato_b);
      6'h03:   bus.i_alu_res = 8'($signed(bus.o_dato_a) >>> bus.o_dato_b);
      6'h02:   bus.i_alu_res = bus.o_dato_a >> bus.o_dato_b;
      default: bus.i_alu_res = 8'h00;
    endcase
  end

  typedef struct {
    logic [7:0] res;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every o_done pulse is matched against the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (bus.o_done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done with result %0h, expected no done",
                 bus.o_result);
      end else begin
        e = sb.pop_front();
        check("done_result", 32'(bus.o_result), 32'(e.res));
        check("done_err", 32'(bus.o_err), 32'(e.err));
        check("done_state", 32'(bus.o_state), 32'd4);
      end
      if (prev_done) check("done_single_cycle", 32'(prev_done & bus.o_done), 32'd0);
    end
    prev_done = bus.o_done;
  end

  task automatic press(input logic [7:0] v, input int hold);
    bus.i_sw   = v;
    bus.i_load = 1'b1;
    repeat (hold) @(negedge clk);
    bus.i_load = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                      input logic [7:0] res, input logic err);
    exp_t e;
    e.res = res;
    e.err = err;
    sb.push_back(e);
    press(a, 2);
    press(b, 2);
    press(op, 2);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    reset      = 1'b1;
    bus.i_load = 1'b0;
    bus.i_sw   = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(bus.o_state), 32'd0);
    check("rst_result", 32'(bus.o_result), 32'd0);
    check("rst_done", 32'(bus.o_done), 32'd0);
    check("rst_err", 32'(bus.o_err), 32'd0);
    check("rst_dato_a", 32'(bus.o_dato_a), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: ADD
    run3(8'h08, 8'h02, 8'h20, 8'h0A, 1'b0);
    check("add_state", 32'(bus.o_state), 32'd4);
    check("add_dato_a", 32'(bus.o_dato_a), 32'h08);
    check("add_dato_b", 32'(bus.o_dato_b), 32'h02);
    check("add_opcode", 32'(bus.o_opcode), 32'h20);

    // 2: SUB from S_DONE, first load held high for several cycles
    e.res = 8'h06;
    e.err = 1'b0;
    sb.push_back(e);
    press(8'h08, 6);
    check("hold_state", 32'(bus.o_state), 32'd1);
    check("hold_dato_a", 32'(bus.o_dato_a), 32'h08);
    press(8'h02, 2);
    press(8'h22, 2);
    repeat (2) @(negedge clk);

    // 3: NOR, OR, XOR
    run3(8'h03, 8'h01, 8'h27, 8'hFC, 1'b0);
    run3(8'h03, 8'h01, 8'h25, 8'h03, 1'b0);
    run3(8'h03, 8'h01, 8'h26, 8'h02, 1'b0);

    // 4: SRA, SRL
    run3(8'h83, 8'h01, 8'h03, 8'hC1, 1'b0);
    run3(8'h83, 8'h01, 8'h02, 8'h41, 1'b0);
    check("srl_result_held", 32'(bus.o_result), 32'h41);

    // 6a: reset in S_OP discards partial loads and clears the result
    press(8'h44, 2);
    press(8'h55, 2);
    check("pre_reset_state", 32'(bus.o_state), 32'd2);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_state", 32'(bus.o_state), 32'd0);
    check("midrst_result", 32'(bus.o_result), 32'd0);
    check("midrst_dato_a", 32'(bus.o_dato_a), 32'd0);
    check("midrst_dato_b", 32'(bus.o_dato_b), 32'd0);
    check("midrst_opcode", 32'(bus.o_opcode), 32'd0);

    // 6b: button held through reset gives no capture until released and pressed again
    bus.i_load = 1'b1;
    bus.i_sw   = 8'h77;
    reset      = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("heldrst_state", 32'(bus.o_state), 32'd0);
    check("heldrst_dato_a", 32'(bus.o_dato_a), 32'd0);
    bus.i_load = 1'b0;
    repeat (2) @(negedge clk);
    e.res = 8'h08;
    e.err = 1'b0;
    sb.push_back(e);
    press(8'h05, 2);
    check("relpress_state", 32'(bus.o_state), 32'd1);
    check("relpress_dato_a", 32'(bus.o_dato_a), 32'h05);
    press(8'h03, 2);
    press(8'h20, 2);
    repeat (2) @(negedge clk);

    // 5: unsupported opcode
    run3(8'h08, 8'h02, 8'h3F, 8'h00, 1'b1);
    check("err_state", 32'(bus.o_state), 32'd4);
    check("err_flag", 32'(bus.o_err), 32'd1);
    check("err_result", 32'(bus.o_result), 32'd0);
    bus.i_sw = 8'h55;
    repeat (3) @(negedge clk);
    check("sw_noload_dato_a", 32'(bus.o_dato_a), 32'h08);
    check("sw_noload_state", 32'(bus.o_state), 32'd4);
    press(8'h11, 2);
    check("errclr_flag", 32'(bus.o_err), 32'd0);
    check("errclr_state", 32'(bus.o_state), 32'd1);
    check("errclr_dato_a", 32'(bus.o_dato_a), 32'h11);

    repeat (4) @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_done: got no done, expected result %0h err %0d", e.res, e.err);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
